// File: rtl/i2c_rx_frame_ctrl.sv
// Frame-level controller for the I2C receive tap: consumes START/bit/STOP symbols,
// assembles MSB-first bytes, gates 9th-bit ACK detection and reports frame status.
module i2c_rx_frame_ctrl #(
  parameter int unsigned CNT_W       = 5,
  parameter int unsigned MAX_BYTES   = 16,
  parameter int unsigned TIMEOUT_CYC = 20000
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             arm,
  output logic             tap_enable,
  output logic             tap_ack_en,
  input  logic [2:0]       tap_data,
  input  logic             tap_valid,
  input  logic             tap_ack_ok,
  output logic             busy,
  output logic [7:0]       byte_data,
  output logic             byte_valid,
  output logic             byte_is_addr,
  output logic             byte_acked,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_len,
  output logic [1:0]       frame_err
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC);
  localparam logic [2:0]  SYM_START = 3'd1;
  localparam logic [2:0]  SYM_BIT1  = 3'd2;
  localparam logic [2:0]  SYM_BIT0  = 3'd3;
  localparam logic [2:0]  SYM_STOP  = 3'd4;

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_SHIFT, ST_ACK} state_e;

  state_e            state_q, state_d;
  logic [7:0]        sr_q, sr_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic              addr_pending_q, addr_pending_d;
  logic [TO_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic              tap_enable_q, tap_enable_d;
  logic              tap_ack_en_q, tap_ack_en_d;
  logic              busy_q, busy_d;
  logic [7:0]        byte_data_q, byte_data_d;
  logic              byte_valid_q, byte_valid_d;
  logic              byte_is_addr_q, byte_is_addr_d;
  logic              byte_acked_q, byte_acked_d;
  logic              frame_done_q, frame_done_d;
  logic [CNT_W-1:0]  frame_len_q, frame_len_d;
  logic [1:0]        frame_err_q, frame_err_d;

  logic   sym_start, sym_bit, sym_stop, in_frame, timeout_c, byte_done, overflow_c, frame_end;
  state_e exit_state;

  assign sym_start  = tap_valid && (tap_data == SYM_START);
  assign sym_bit    = tap_valid && ((tap_data == SYM_BIT1) || (tap_data == SYM_BIT0));
  assign sym_stop   = tap_valid && (tap_data == SYM_STOP);
  assign in_frame   = (state_q == ST_SHIFT) || (state_q == ST_ACK);
  assign timeout_c  = in_frame && !tap_valid && (idle_cnt_q == TO_W'(TIMEOUT_CYC - 1));
  assign byte_done  = (state_q == ST_ACK) && sym_bit;
  assign overflow_c = byte_done && (32'(byte_cnt_q) >= MAX_BYTES);
  assign frame_end  = in_frame && (sym_stop || overflow_c || timeout_c);
  assign exit_state = arm ? ST_ARMED : ST_IDLE;

  // State and registered outputs
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      sr_q           <= '0;
      bit_cnt_q      <= '0;
      byte_cnt_q     <= '0;
      addr_pending_q <= 1'b0;
      idle_cnt_q     <= '0;
      tap_enable_q   <= 1'b0;
      tap_ack_en_q   <= 1'b0;
      busy_q         <= 1'b0;
      byte_data_q    <= '0;
      byte_valid_q   <= 1'b0;
      byte_is_addr_q <= 1'b0;
      byte_acked_q   <= 1'b0;
      frame_done_q   <= 1'b0;
      frame_len_q    <= '0;
      frame_err_q    <= '0;
    end else begin
      state_q        <= state_d;
      sr_q           <= sr_d;
      bit_cnt_q      <= bit_cnt_d;
      byte_cnt_q     <= byte_cnt_d;
      addr_pending_q <= addr_pending_d;
      idle_cnt_q     <= idle_cnt_d;
      tap_enable_q   <= tap_enable_d;
      tap_ack_en_q   <= tap_ack_en_d;
      busy_q         <= busy_d;
      byte_data_q    <= byte_data_d;
      byte_valid_q   <= byte_valid_d;
      byte_is_addr_q <= byte_is_addr_d;
      byte_acked_q   <= byte_acked_d;
      frame_done_q   <= frame_done_d;
      frame_len_q    <= frame_len_d;
      frame_err_q    <= frame_err_d;
    end
  end

  // Next-state logic; any frame end takes priority over bit progress
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (arm) state_d = ST_ARMED;
      ST_ARMED: begin
        if (!arm)           state_d = ST_IDLE;
        else if (sym_start) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (frame_end)                         state_d = exit_state;
        else if (sym_bit && bit_cnt_q == 3'd7) state_d = ST_ACK;
      end
      ST_ACK: begin
        if (frame_end)                 state_d = exit_state;
        else if (sym_bit || sym_start) state_d = ST_SHIFT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    sr_d           = sr_q;
    bit_cnt_d      = bit_cnt_q;
    byte_cnt_d     = byte_cnt_q;
    addr_pending_d = addr_pending_q;
    byte_data_d    = byte_data_q;
    byte_is_addr_d = byte_is_addr_q;
    byte_acked_d   = byte_acked_q;
    frame_len_d    = frame_len_q;
    frame_err_d    = frame_err_q;
    byte_valid_d   = 1'b0;
    frame_done_d   = 1'b0;
    tap_enable_d   = (state_d != ST_IDLE);
    tap_ack_en_d   = (state_d == ST_ACK);
    busy_d         = (state_d == ST_SHIFT) || (state_d == ST_ACK);
    idle_cnt_d     = (tap_valid || !busy_d) ? '0 : idle_cnt_q + TO_W'(1);

    if (state_q == ST_ARMED && state_d == ST_SHIFT) begin
      sr_d           = '0;
      bit_cnt_d      = '0;
      byte_cnt_d     = '0;
      addr_pending_d = 1'b1;
    end else if (in_frame && sym_start) begin
      // Repeated START drops any partial byte but keeps the frame's byte count
      sr_d           = '0;
      bit_cnt_d      = '0;
      addr_pending_d = 1'b1;
    end else if (state_q == ST_SHIFT && sym_bit) begin
      sr_d      = {sr_q[6:0], (tap_data == SYM_BIT1)};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end else if (byte_done) begin
      byte_valid_d   = 1'b1;
      byte_data_d    = sr_q;
      byte_acked_d   = tap_ack_ok;
      byte_is_addr_d = addr_pending_q;
      addr_pending_d = 1'b0;
      bit_cnt_d      = '0;
      if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + CNT_W'(1);
    end

    if (frame_end) begin
      frame_done_d = 1'b1;
      frame_len_d  = byte_cnt_q;
      if (overflow_c) begin
        frame_err_d = 2'd3;
        frame_len_d = CNT_W'(MAX_BYTES);
      end else if (sym_stop) begin
        frame_err_d = ((state_q == ST_ACK) || (bit_cnt_q != '0)) ? 2'd1 : 2'd0;
      end else begin
        frame_err_d = 2'd2;
      end
    end
  end

  assign tap_enable   = tap_enable_q;
  assign tap_ack_en   = tap_ack_en_q;
  assign busy         = busy_q;
  assign byte_data    = byte_data_q;
  assign byte_valid   = byte_valid_q;
  assign byte_is_addr = byte_is_addr_q;
  assign byte_acked   = byte_acked_q;
  assign frame_done   = frame_done_q;
  assign frame_len    = frame_len_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_i2c_rx_frame_ctrl.sv
// Bench for i2c_rx_frame_ctrl: directed frame scenarios plus random symbol streams
// compared against a frame-level reference model.
module tb_i2c_rx_frame_ctrl;

  localparam int unsigned CNT_W       = 5;
  localparam int unsigned MAX_BYTES   = 2;
  localparam int unsigned TIMEOUT_CYC = 100;
  localparam logic [2:0]  S_START = 3'd1, S_B1 = 3'd2, S_B0 = 3'd3, S_STOP = 3'd4;

  typedef struct packed { logic [7:0] data; logic addr; logic acked; } byte_rec_t;
  typedef struct packed { logic [CNT_W-1:0] len; logic [1:0] err; } frame_rec_t;
  typedef struct packed { logic [2:0] code; logic ack; } sym_t;

  logic             clock = 1'b0;
  logic             rst_n = 1'b0;
  logic             arm = 1'b0;
  logic [2:0]       tap_data = 3'd0;
  logic             tap_valid = 1'b0;
  logic             tap_ack_ok = 1'b0;
  logic             tap_enable, tap_ack_en, busy;
  logic [7:0]       byte_data;
  logic             byte_valid, byte_is_addr, byte_acked, frame_done;
  logic [CNT_W-1:0] frame_len;
  logic [1:0]       frame_err;

  i2c_rx_frame_ctrl #(.CNT_W(CNT_W), .MAX_BYTES(MAX_BYTES), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clock(clock), .rst_n(rst_n), .arm(arm), .tap_enable(tap_enable), .tap_ack_en(tap_ack_en),
    .tap_data(tap_data), .tap_valid(tap_valid), .tap_ack_ok(tap_ack_ok), .busy(busy),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_is_addr(byte_is_addr),
    .byte_acked(byte_acked), .frame_done(frame_done), .frame_len(frame_len), .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  byte_rec_t  obs_b[$], exp_b[$];
  frame_rec_t obs_f[$], exp_f[$];
  sym_t       syms[$];

  // Strobe monitor
  always @(negedge clock) begin
    if (rst_n) begin
      if (byte_valid) obs_b.push_back({byte_data, byte_is_addr, byte_acked});
      if (frame_done) obs_f.push_back({frame_len, frame_err});
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Called at a falling edge; one-cycle symbol strobe followed by idle gap cycles
  task automatic drive_sym(input logic [2:0] code, input logic ack, input int gap);
    tap_data = code; tap_valid = 1'b1; tap_ack_ok = ack;
    @(negedge clock);
    tap_valid = 1'b0; tap_ack_ok = 1'b0; tap_data = 3'd0;
    repeat (gap) @(negedge clock);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, input int gap);
    for (int i = 0; i < n; i++) drive_sym(b[7-i] ? S_B1 : S_B0, 1'b0, gap);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ack, input int gap);
    send_bits(b, 8, gap);
    drive_sym(ack ? S_B0 : S_B1, ack, gap);
  endtask

  task automatic do_reset();
    tap_valid = 1'b0; tap_ack_ok = 1'b0; tap_data = 3'd0; arm = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clock);
    rst_n = 1'b1; arm = 1'b1;
    repeat (2) @(negedge clock);
    obs_b.delete(); obs_f.delete();
  endtask

  task automatic test_reset();
    arm = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++;
    if ({tap_enable, tap_ack_en, busy, byte_data, byte_valid, byte_is_addr, byte_acked,
         frame_done, frame_len, frame_err} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    end
    rst_n = 1'b1;
    @(negedge clock);
    arm = 1'b1;
    n_checks++;
    if (tap_enable !== 1'b0) begin n_fail++; $display("FAIL idle_enable: got %b want 0", tap_enable); end
    @(negedge clock);
    n_checks++;
    if (tap_enable !== 1'b1) begin n_fail++; $display("FAIL arm_enable: got %b want 1", tap_enable); end
  endtask

  task automatic test_basic();
    do_reset();
    drive_sym(S_START, 1'b0, 1);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
    send_bits(8'hA0, 8, 0);
    n_checks++;
    if (tap_ack_en !== 1'b1) begin n_fail++; $display("FAIL basic_ack_en: got %b want 1", tap_ack_en); end
    drive_sym(S_B0, 1'b1, 0);
    n_checks++;
    if ({byte_valid, byte_data, byte_is_addr, byte_acked, tap_ack_en} !== {1'b1, 8'hA0, 1'b1, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL basic_byte1: got v=%b d=%h a=%b k=%b ae=%b want v=1 d=a0 a=1 k=1 ae=0",
                         byte_valid, byte_data, byte_is_addr, byte_acked, tap_ack_en);
    end
    @(negedge clock);
    n_checks++;
    if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL basic_strobe: got %b want 0", byte_valid); end
    send_byte(8'h5A, 1'b1, 1);
    drive_sym(S_STOP, 1'b0, 0);
    n_checks++;
    if ({frame_done, frame_len, frame_err, busy} !== {1'b1, CNT_W'(2), 2'd0, 1'b0}) begin
      n_fail++; $display("FAIL basic_frame: got done=%b len=%0d err=%0d busy=%b want 1 2 0 0",
                         frame_done, frame_len, frame_err, busy);
    end
    @(negedge clock);
    n_checks++;
    if (obs_b.size() != 2 || obs_b[1] !== {8'h5A, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL basic_byte2: got n=%0d last=%h want n=2 last=%h",
                         obs_b.size(), (obs_b.size() > 0) ? obs_b[obs_b.size()-1] : '0, {8'h5A, 1'b0, 1'b1});
    end
  endtask

  task automatic test_nack();
    do_reset();
    drive_sym(S_START, 1'b0, 1);
    send_byte(8'hA1, 1'b0, 1);
    drive_sym(S_STOP, 1'b0, 2);
    n_checks++;
    if (obs_b.size() != 1 || obs_b[0] !== {8'hA1, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL nack_byte: got n=%0d rec=%h want n=1 rec=%h",
                         obs_b.size(), (obs_b.size() > 0) ? obs_b[0] : '0, {8'hA1, 1'b1, 1'b0});
    end
    n_checks++;
    if (obs_f.size() != 1 || obs_f[0] !== {CNT_W'(1), 2'd0}) begin
      n_fail++; $display("FAIL nack_frame: got n=%0d rec=%h want n=1 len=1 err=0",
                         obs_f.size(), (obs_f.size() > 0) ? obs_f[0] : '0);
    end
  endtask

  task automatic test_rep_start();
    do_reset();
    drive_sym(S_START, 1'b0, 1);
    send_byte(8'hA0, 1'b1, 1);
    drive_sym(S_START, 1'b0, 1);
    send_byte(8'hA1, 1'b1, 1);
    drive_sym(S_STOP, 1'b0, 2);
    n_checks++;
    if (obs_b.size() != 2 || obs_b[1] !== {8'hA1, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL rep_start_byte: got n=%0d want n=2 with second byte a1 addr=1", obs_b.size());
    end
    n_checks++;
    if (obs_f.size() != 1 || obs_f[0] !== {CNT_W'(2), 2'd0}) begin
      n_fail++; $display("FAIL rep_start_frame: got n=%0d rec=%h want len=2 err=0",
                         obs_f.size(), (obs_f.size() > 0) ? obs_f[0] : '0);
    end
  endtask

  task automatic test_partial();
    do_reset();
    drive_sym(S_START, 1'b0, 1);
    send_bits(8'hFF, 5, 1);
    drive_sym(S_STOP, 1'b0, 0);
    n_checks++;
    if ({frame_done, frame_len, frame_err, byte_valid} !== {1'b1, CNT_W'(0), 2'd1, 1'b0}) begin
      n_fail++; $display("FAIL partial_shift: got done=%b len=%0d err=%0d bv=%b want 1 0 1 0",
                         frame_done, frame_len, frame_err, byte_valid);
    end
    drive_sym(S_START, 1'b0, 1);
    send_bits(8'h3C, 8, 1);
    drive_sym(S_STOP, 1'b0, 0);
    n_checks++;
    if ({frame_done, frame_len, frame_err} !== {1'b1, CNT_W'(0), 2'd1}) begin
      n_fail++; $display("FAIL partial_ack: got done=%b len=%0d err=%0d want 1 0 1", frame_done, frame_len, frame_err);
    end
    n_checks++;
    if (obs_b.size() != 0) begin n_fail++; $display("FAIL partial_nobyte: got %0d bytes want 0", obs_b.size()); end
  endtask

  task automatic test_timeout();
    do_reset();
    drive_sym(S_START, 1'b0, 1);
    send_bits(8'hE0, 3, 0);
    repeat (TIMEOUT_CYC - 1) @(negedge clock);
    n_checks++;
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got done=%b want 0", frame_done); end
    @(negedge clock);
    n_checks++;
    if ({frame_done, frame_len, frame_err, busy, tap_enable} !== {1'b1, CNT_W'(0), 2'd2, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL timeout_frame: got done=%b len=%0d err=%0d busy=%b en=%b want 1 0 2 0 1",
                         frame_done, frame_len, frame_err, busy, tap_enable);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    drive_sym(S_START, 1'b0, 1);
    send_byte(8'h11, 1'b1, 1);
    send_byte(8'h22, 1'b1, 1);
    send_bits(8'h33, 8, 1);
    drive_sym(S_B0, 1'b1, 0);
    n_checks++;
    if ({byte_valid, byte_data, frame_done, frame_len, frame_err, busy} !==
        {1'b1, 8'h33, 1'b1, CNT_W'(MAX_BYTES), 2'd3, 1'b0}) begin
      n_fail++; $display("FAIL overflow_frame: got bv=%b d=%h done=%b len=%0d err=%0d busy=%b want 1 33 1 %0d 3 0",
                         byte_valid, byte_data, frame_done, frame_len, frame_err, busy, MAX_BYTES);
    end
    send_byte(8'h44, 1'b1, 0);
    drive_sym(S_STOP, 1'b0, 2);
    n_checks++;
    if (obs_b.size() != 3 || obs_f.size() != 1) begin
      n_fail++; $display("FAIL overflow_ignore: got bytes=%0d frames=%0d want 3 1", obs_b.size(), obs_f.size());
    end
  endtask

  task automatic test_arm_drop();
    do_reset();
    drive_sym(S_START, 1'b0, 1);
    send_byte(8'h90, 1'b1, 1);
    arm = 1'b0;
    send_byte(8'h07, 1'b1, 1);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL arm_drop_busy: got %b want 1", busy); end
    drive_sym(S_STOP, 1'b0, 0);
    n_checks++;
    if ({frame_done, frame_len, frame_err, tap_enable} !== {1'b1, CNT_W'(2), 2'd0, 1'b0}) begin
      n_fail++; $display("FAIL arm_drop_exit: got done=%b len=%0d err=%0d en=%b want 1 2 0 0",
                         frame_done, frame_len, frame_err, tap_enable);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_sym(S_START, 1'b0, 1);
    send_bits(8'hC3, 8, 1);
    n_checks++;
    if (tap_ack_en !== 1'b1) begin n_fail++; $display("FAIL mid_ack_en: got %b want 1", tap_ack_en); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({tap_enable, tap_ack_en, busy, byte_data, byte_valid, byte_is_addr, byte_acked,
         frame_done, frame_len, frame_err} !== '0) begin
      n_fail++; $display("FAIL mid_reset: got en=%b ae=%b busy=%b done=%b want all outputs 0",
                         tap_enable, tap_ack_en, busy, frame_done);
    end
    @(negedge clock);
    rst_n = 1'b1;
  endtask

  // Reference: walks the symbol list with frame-level rules; nbits==8 means waiting for the 9th bit
  task automatic model();
    bit in_frame = 0;
    bit addr = 0;
    int nbits = 0;
    int nbytes = 0;
    logic [7:0] acc = '0;
    exp_b.delete(); exp_f.delete();
    foreach (syms[i]) begin
      if (!in_frame) begin
        if (syms[i].code == S_START) begin in_frame = 1; addr = 1; nbits = 0; nbytes = 0; end
      end else if (syms[i].code == S_START) begin
        addr = 1; nbits = 0;
      end else if (syms[i].code == S_STOP) begin
        exp_f.push_back({CNT_W'(nbytes), (nbits != 0) ? 2'd1 : 2'd0});
        in_frame = 0;
      end else if (syms[i].code == S_B1 || syms[i].code == S_B0) begin
        if (nbits < 8) begin
          acc = {acc[6:0], syms[i].code == S_B1};
          nbits++;
        end else begin
          exp_b.push_back({acc, addr, syms[i].ack});
          addr = 0; nbits = 0; nbytes++;
          if (nbytes > int'(MAX_BYTES)) begin
            exp_f.push_back({CNT_W'(MAX_BYTES), 2'd3});
            in_frame = 0;
          end
        end
      end
    end
  endtask

  task automatic test_random(input int nsym, input int maxgap, input string tag);
    int r;
    int k;
    logic [2:0] code;
    do_reset();
    syms.delete();
    syms.push_back({S_START, 1'b0});
    for (int i = 0; i < nsym; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8)       code = S_START;
      else if (r < 48) code = S_B1;
      else if (r < 86) code = S_B0;
      else if (r < 93) code = S_STOP;
      else begin
        k = $urandom_range(0, 3);
        code = (k == 0) ? 3'd0 : 3'(k + 4);
      end
      syms.push_back({code, 1'($urandom_range(0, 1))});
    end
    syms.push_back({S_STOP, 1'b0});
    foreach (syms[i]) drive_sym(syms[i].code, syms[i].ack, $urandom_range(0, maxgap));
    repeat (3) @(negedge clock);
    model();
    n_checks++;
    if (obs_b.size() != exp_b.size()) begin
      n_fail++; $display("FAIL %s_nbytes: got %0d want %0d", tag, obs_b.size(), exp_b.size());
    end
    for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
      n_checks++;
      if (obs_b[i] !== exp_b[i]) begin
        n_fail++; $display("FAIL %s_byte[%0d]: got %h want %h", tag, i, obs_b[i], exp_b[i]);
      end
    end
    n_checks++;
    if (obs_f.size() != exp_f.size()) begin
      n_fail++; $display("FAIL %s_nframes: got %0d want %0d", tag, obs_f.size(), exp_f.size());
    end
    for (int i = 0; i < exp_f.size() && i < obs_f.size(); i++) begin
      n_checks++;
      if (obs_f[i] !== exp_f[i]) begin
        n_fail++; $display("FAIL %s_frame[%0d]: got %h want %h", tag, i, obs_f[i], exp_f[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nack();
    test_rep_start();
    test_partial();
    test_timeout();
    test_overflow();
    test_arm_drop();
    test_reset_mid();
    test_random(400, 3, "random");
    test_random(400, 0, "back_to_back");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
